// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time
// and loads the IF/ID register, honouring stall and branch flush/redirect.
module if_fetch_stage #(
  parameter int                 PC_W      = 9,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    if_id_Curr_Pc,
  output logic [INSTR_W-1:0] if_id_Curr_Instr,
  output logic               if_id_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               deliver;

  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] a);
    return a + PC_W'(4);
  endfunction

  // The request is gated by reset so the port reads idle while reset is held.
  assign imem_req  = (state == S_REQ) && !flush && !reset;
  assign imem_addr = pc;
  assign deliver   = !flush && !stall &&
                     (((state == S_WAIT) && imem_rvalid) || (state == S_HOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      hold_instr       <= NOP_INSTR;
      if_id_Curr_Pc    <= '0;
      if_id_Curr_Instr <= NOP_INSTR;
      if_id_valid      <= 1'b0;
    end else begin
      if (flush)
        pc <= align_word(branch_target);
      else if (deliver)
        pc <= next_pc(pc);

      case (state)
        S_REQ:  if (!flush) state <= S_WAIT;
        S_WAIT: begin
          if (flush) begin
            state <= imem_rvalid ? S_REQ : S_DROP;
          end else if (imem_rvalid) begin
            if (stall) begin
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD: if (flush || !stall) state <= S_REQ;
        S_DROP: if (imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      // IF/ID register: flush beats stall, stall freezes, otherwise load or bubble.
      if (flush) begin
        if_id_valid      <= 1'b0;
        if_id_Curr_Instr <= NOP_INSTR;
      end else if (!stall) begin
        if (deliver) begin
          if_id_Curr_Pc    <= pc;
          if_id_Curr_Instr <= (state == S_HOLD) ? hold_instr : imem_rdata;
          if_id_valid      <= 1'b1;
        end else begin
          if_id_Curr_Instr <= NOP_INSTR;
          if_id_valid      <= 1'b0;
        end
      end
    end
  end

endmodule
